add_share_arbiter: RTL and testbench
====================================

ADD_SHARE_ARBITER -- requirements
Module: add_share_arbiter

Interface
REQ-001 Parameter DATAWIDTH, default 32: operand and sum width in bits.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Clk  in  1  rising-edge clock for all state.
REQ-004 Rst  in  1  synchronous, active-high reset.
REQ-005 req  in  4  per-requester add request; bit i = requester i.
REQ-006 a  in  4*DATAWIDTH  packed operand A; requester i at [i*DATAWIDTH +: DATAWIDTH].
REQ-007 b  in  4*DATAWIDTH  packed operand B; same packing as a.
REQ-008 gnt  out  4  one-hot grant; operands of granted requester sampled this cycle.
REQ-009 sum  out  DATAWIDTH  registered result of granted a+b.
REQ-010 sum_ovf  out  1  carry-out of the registered addition.
REQ-011 sum_id  out  2  index of requester owning sum.
REQ-012 sum_valid  out  1  sum/sum_ovf/sum_id hold a result not yet consumed.
REQ-013 sum_ready  in  1  consumer takes result when sum_valid && sum_ready at Clk edge.

Function
REQ-014 The block SHALL share one DATAWIDTH adder among 4 requesters, one operation accepted per cycle at most.
REQ-015 The output register SHALL have two states: EMPTY (sum_valid=0), FULL (sum_valid=1).
REQ-016 Accept condition: |req && !Rst && (EMPTY || sum_ready).
REQ-017 gnt SHALL be combinational, all-zero unless accept condition holds, then exactly one bit set.
REQ-018 Arbitration SHALL be round-robin: winner = first i with req[i]=1 searching ptr, ptr+1, ... mod 4.
REQ-019 On accept of requester i: sum <= (a_i + b_i) mod 2^DATAWIDTH, sum_ovf <= carry bit DATAWIDTH, sum_id <= i, sum_valid <= 1, ptr <= (i+1) mod 4.
REQ-020 Latency SHALL be 1 cycle: result visible the cycle after gnt.
REQ-021 FULL && !sum_ready: sum, sum_ovf, sum_id, sum_valid, ptr SHALL hold; gnt=0.
REQ-022 FULL && sum_ready && no accept: sum_valid <= 0 (EMPTY); sum, sum_ovf, sum_id hold last values.
REQ-023 FULL && sum_ready && accept: new result replaces old same edge, sum_valid stays 1 (full throughput, 1 result/cycle).
REQ-024 sum_ready SHALL be ignored in EMPTY.
REQ-025 ptr SHALL change only on accept; unserved requesters keep priority order.
REQ-026 Requester SHALL hold a/b stable while req=1 without gnt; req may drop before gnt with no effect.
REQ-027 A requester holding req after gnt SHALL be treated as a new request, eligible per round-robin.
REQ-028 Addition SHALL be unsigned; no saturation.

Reset
REQ-029 Rst=1 at Clk edge SHALL set ptr=0, sum=0, sum_ovf=0, sum_id=0, sum_valid=0 (EMPTY).
REQ-030 gnt SHALL be 0 in any cycle with Rst=1.
REQ-031 Reset mid-operation SHALL discard any pending unconsumed result; no request is granted in the reset cycle.

Verification
REQ-032 After reset, req=0001, a0=5, b0=7 -> gnt=0001 same cycle; next cycle sum=12, sum_id=0, sum_valid=1, sum_ovf=0.
REQ-033 req=1111 held, sum_ready=1, ptr=0 -> gnt 0001,0010,0100,1000,0001 on 5 consecutive cycles; sum_id 0,1,2,3,0 one cycle later.
REQ-034 DATAWIDTH=8, a=0xFF, b=0x02 -> sum=0x01, sum_ovf=1.
REQ-035 sum_valid=1, sum_ready=0, req=0010 for 3 cycles -> gnt=0, outputs stable; sum_ready=1 -> gnt=0010 that cycle, new sum next cycle, sum_valid stays 1.
REQ-036 Last grant to requester 3, req=1001 -> gnt=0001; then req=1001 -> gnt=1000.
REQ-037 sum_valid=1 pending, Rst=1 one cycle -> sum_valid=0, sum=0; then req=1001 -> gnt=0001.

Source files
------------

// File: rtl/add_share_arbiter_if.sv
// Request/result bundle for the shared-adder arbiter.
// master drives requests and consumes results; slave is the arbiter.
interface add_share_arbiter_if #(
  parameter int DATAWIDTH = 32
);
  logic [3:0]             req;
  logic [4*DATAWIDTH-1:0] a;
  logic [4*DATAWIDTH-1:0] b;
  logic [3:0]             gnt;
  logic [DATAWIDTH-1:0]   sum;
  logic                   sum_ovf;
  logic [1:0]             sum_id;
  logic                   sum_valid;
  logic                   sum_ready;

  modport master (
    output req, a, b, sum_ready,
    input  gnt, sum, sum_ovf, sum_id, sum_valid
  );

  modport slave (
    input  req, a, b, sum_ready,
    output gnt, sum, sum_ovf, sum_id, sum_valid
  );
endinterface

// File: rtl/add_share_arbiter.sv
// Four requesters share one adder under round-robin arbitration.
// One-deep output register with valid/ready; one result per cycle.
module add_share_arbiter #(
  parameter int DATAWIDTH = 32
) (
  input logic                Clk,
  input logic                Rst,
  add_share_arbiter_if.slave bus
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [1:0]           ptr;
  logic [1:0]           win;
  logic [1:0]           idx;
  logic                 found;
  logic                 accept;
  logic [DATAWIDTH-1:0] op_a;
  logic [DATAWIDTH-1:0] op_b;
  logic [DATAWIDTH:0]   add_res;

  // Round-robin search starting at ptr for the first active request.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Accept when a request exists and the output slot is free or draining.
  always_comb begin
    accept  = found && !Rst && (state == EMPTY || bus.sum_ready);
    bus.gnt = accept ? (4'b0001 << win) : 4'b0000;
    op_a    = bus.a[win*DATAWIDTH +: DATAWIDTH];
    op_b    = bus.b[win*DATAWIDTH +: DATAWIDTH];
    add_res = {1'b0, op_a} + {1'b0, op_b};
  end

  // Output slot occupancy: load keeps it full, drain without load empties.
  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: if (accept) state_nxt = FULL;
      FULL:  if (!accept && bus.sum_ready) state_nxt = EMPTY;
    endcase
  end

  // Occupancy state register.
  always_ff @(posedge Clk) begin
    if (Rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Result register and priority pointer; both move only on accept.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      ptr         <= 2'd0;
      bus.sum     <= '0;
      bus.sum_ovf <= 1'b0;
      bus.sum_id  <= 2'd0;
    end else if (accept) begin
      ptr         <= win + 2'd1;
      bus.sum     <= add_res[DATAWIDTH-1:0];
      bus.sum_ovf <= add_res[DATAWIDTH];
      bus.sum_id  <= win;
    end
  end

  assign bus.sum_valid = (state == FULL);

endmodule

// File: tb/tb_add_share_arbiter.sv
// Self-checking bench for add_share_arbiter.
// Scoreboard queue holds results expected from the reference model.
module tb_add_share_arbiter;

  localparam int DW = 8;

  logic Clk;
  logic Rst;
  int   checks;
  int   errors;

  logic [DW-1:0]  ta [4];
  logic [DW-1:0]  tb_b [4];
  logic [DW+2:0]  q [$];
  logic [1:0]     m_ptr;
  logic [3:0]     g;

  add_share_arbiter_if #(.DATAWIDTH(DW)) bus ();

  add_share_arbiter #(.DATAWIDTH(DW)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // One clock cycle: drive, check against the model, advance the model.
  task automatic cycle(input logic [3:0] r, input logic rdy,
                       input logic rs, output logic [3:0] go);
    logic [3:0]    eg;
    logic [1:0]    w;
    logic          fnd;
    logic          acc;
    logic [DW:0]   s;
    logic [1:0]    ix;
    bus.req       = r;
    bus.sum_ready = rdy;
    Rst           = rs;
    for (int i = 0; i < 4; i++) begin
      bus.a[i*DW +: DW] = ta[i];
      bus.b[i*DW +: DW] = tb_b[i];
    end
    #1;
    fnd = 1'b0;
    w   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      ix = m_ptr + 2'(k);
      if (!fnd && r[ix]) begin
        fnd = 1'b1;
        w   = ix;
      end
    end
    acc = fnd && !rs && (q.size() == 0 || rdy);
    eg  = acc ? (4'b0001 << w) : 4'b0000;
    checks++;
    if (bus.gnt !== eg) begin
      errors++;
      $display("FAIL gnt: got %b want %b", bus.gnt, eg);
    end
    checks++;
    if (bus.sum_valid !== (q.size() != 0)) begin
      errors++;
      $display("FAIL sum_valid: got %b want %b", bus.sum_valid, q.size() != 0);
    end
    if (q.size() != 0) begin
      checks++;
      if ({bus.sum_id, bus.sum_ovf, bus.sum} !== q[0]) begin
        errors++;
        $display("FAIL result: got id%0d ovf%0d sum%h want id%0d ovf%0d sum%h",
                 bus.sum_id, bus.sum_ovf, bus.sum,
                 q[0][DW+2:DW+1], q[0][DW], q[0][DW-1:0]);
      end
    end
    go = bus.gnt;
    if (rs) begin
      q.delete();
      m_ptr = 2'd0;
    end else begin
      if (q.size() != 0 && rdy) void'(q.pop_front());
      if (acc) begin
        s = {1'b0, ta[w]} + {1'b0, tb_b[w]};
        q.push_back({w, s});
        m_ptr = w + 2'd1;
      end
    end
    @(negedge Clk);
  endtask

  task automatic test_reset;
    cycle(4'b1111, 1'b1, 1'b1, g);
    checks++;
    if (g !== 4'b0000) begin
      errors++;
      $display("FAIL reset_gnt: got %b want 0000", g);
    end
    #1;
    checks++;
    if ({bus.sum_valid, bus.sum, bus.sum_ovf, bus.sum_id} !== '0) begin
      errors++;
      $display("FAIL reset_state: got v%b s%h o%b id%0d want all zero",
               bus.sum_valid, bus.sum, bus.sum_ovf, bus.sum_id);
    end
  endtask

  task automatic test_basic;
    ta[0] = 8'd5;
    tb_b[0] = 8'd7;
    cycle(4'b0001, 1'b1, 1'b0, g);
    checks++;
    if (g !== 4'b0001) begin
      errors++;
      $display("FAIL basic_gnt: got %b want 0001", g);
    end
    #1;
    checks++;
    if ({bus.sum_valid, bus.sum_id, bus.sum_ovf, bus.sum} !== {1'b1, 2'd0, 1'b0, 8'd12}) begin
      errors++;
      $display("FAIL basic_sum: got v%b id%0d o%b s%0d want v1 id0 o0 s12",
               bus.sum_valid, bus.sum_id, bus.sum_ovf, bus.sum);
    end
    cycle(4'b0000, 1'b1, 1'b0, g);
  endtask

  task automatic test_round_robin;
    logic [3:0] want [5];
    want = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 4; i++) begin
      ta[i] = 8'(10 * i + 1);
      tb_b[i] = 8'(i + 3);
    end
    cycle(4'b0000, 1'b1, 1'b1, g);
    for (int i = 0; i < 5; i++) begin
      cycle(4'b1111, 1'b1, 1'b0, g);
      checks++;
      if (g !== want[i]) begin
        errors++;
        $display("FAIL rr_gnt%0d: got %b want %b", i, g, want[i]);
      end
    end
    cycle(4'b0000, 1'b1, 1'b0, g);
  endtask

  task automatic test_overflow;
    ta[2] = 8'hFF;
    tb_b[2] = 8'h02;
    cycle(4'b0100, 1'b1, 1'b0, g);
    #1;
    checks++;
    if ({bus.sum_ovf, bus.sum} !== {1'b1, 8'h01}) begin
      errors++;
      $display("FAIL ovf: got o%b s%h want o1 s01", bus.sum_ovf, bus.sum);
    end
    cycle(4'b0000, 1'b1, 1'b0, g);
  endtask

  task automatic test_backpressure;
    ta[0] = 8'd20;
    tb_b[0] = 8'd22;
    ta[1] = 8'd100;
    tb_b[1] = 8'd50;
    cycle(4'b0001, 1'b0, 1'b0, g);
    for (int i = 0; i < 3; i++) begin
      cycle(4'b0010, 1'b0, 1'b0, g);
      checks++;
      if (g !== 4'b0000) begin
        errors++;
        $display("FAIL bp_hold%0d: got %b want 0000", i, g);
      end
    end
    cycle(4'b0010, 1'b1, 1'b0, g);
    checks++;
    if (g !== 4'b0010) begin
      errors++;
      $display("FAIL bp_release: got %b want 0010", g);
    end
    #1;
    checks++;
    if ({bus.sum_valid, bus.sum_id, bus.sum} !== {1'b1, 2'd1, 8'd150}) begin
      errors++;
      $display("FAIL bp_sum: got v%b id%0d s%0d want v1 id1 s150",
               bus.sum_valid, bus.sum_id, bus.sum);
    end
    cycle(4'b0000, 1'b1, 1'b0, g);
  endtask

  task automatic test_wrap;
    cycle(4'b1000, 1'b1, 1'b0, g);
    cycle(4'b1001, 1'b1, 1'b0, g);
    checks++;
    if (g !== 4'b0001) begin
      errors++;
      $display("FAIL wrap_first: got %b want 0001", g);
    end
    cycle(4'b1001, 1'b1, 1'b0, g);
    checks++;
    if (g !== 4'b1000) begin
      errors++;
      $display("FAIL wrap_second: got %b want 1000", g);
    end
    cycle(4'b0000, 1'b1, 1'b0, g);
  endtask

  task automatic test_reset_mid;
    cycle(4'b0010, 1'b0, 1'b0, g);
    cycle(4'b0100, 1'b1, 1'b1, g);
    #1;
    checks++;
    if ({bus.sum_valid, bus.sum} !== {1'b0, 8'd0}) begin
      errors++;
      $display("FAIL mid_reset: got v%b s%h want v0 s00", bus.sum_valid, bus.sum);
    end
    cycle(4'b1001, 1'b1, 1'b0, g);
    checks++;
    if (g !== 4'b0001) begin
      errors++;
      $display("FAIL mid_after: got %b want 0001", g);
    end
    cycle(4'b0000, 1'b1, 1'b0, g);
  endtask

  task automatic test_random;
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 4; i++) begin
        ta[i] = 8'($urandom);
        tb_b[i] = 8'($urandom);
      end
      cycle(4'($urandom), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 40) == 0), g);
    end
    cycle(4'b0000, 1'b1, 1'b0, g);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_ptr  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      ta[i] = '0;
      tb_b[i] = '0;
    end
    Rst           = 1'b1;
    bus.req       = 4'b0000;
    bus.sum_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    test_reset;
    test_basic;
    test_round_robin;
    test_overflow;
    test_backpressure;
    test_wrap;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
